// File: rtl/divider_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : divider_arbiter_pkg
// Purpose  : Shared constants for clients of the single-precision divider:
//            arbiter state encoding, FP32 width and canonical quiet NaN.
// Revision : 1.0 - initial release
// ============================================================================
package divider_arbiter_pkg;

    localparam int c_FP32_W = 32;

    typedef logic [c_FP32_W-1:0] fp32_t;

    localparam fp32_t c_QNAN = 32'hFFC0_0000;

    // Arbiter state encoding
    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_SEND_A = 3'd1;
    localparam logic [2:0] c_SEND_B = 3'd2;
    localparam logic [2:0] c_WAIT_Z = 3'd3;
    localparam logic [2:0] c_RESP   = 3'd4;

endpackage : divider_arbiter_pkg
`default_nettype wire

// File: rtl/divider_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : divider_arbiter_if
// Purpose  : Requester bus and divider strobe/ack bus of the divider arbiter.
//            slave  = arbiter side, master = clients + divider side.
// Revision : 1.0 - initial release
// ============================================================================
interface divider_arbiter_if
    import divider_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) ();

    logic [N_REQ-1:0]          req_valid;
    logic [c_FP32_W*N_REQ-1:0] req_a;
    logic [c_FP32_W*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]          req_ready;
    logic [N_REQ-1:0]          rsp_valid;
    fp32_t                     rsp_z;
    logic [N_REQ-1:0]          rsp_ready;
    logic                      busy;

    logic                      div_rst;
    fp32_t                     div_input_a;
    logic                      div_input_a_stb;
    logic                      div_input_a_ack;
    fp32_t                     div_input_b;
    logic                      div_input_b_stb;
    logic                      div_input_b_ack;
    fp32_t                     div_output_z;
    logic                      div_output_z_stb;
    logic                      div_output_z_ack;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        input  div_input_a_ack, div_input_b_ack, div_output_z, div_output_z_stb,
        output req_ready, rsp_valid, rsp_z, busy,
        output div_rst, div_input_a, div_input_a_stb, div_input_b, div_input_b_stb,
        output div_output_z_ack
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        output div_input_a_ack, div_input_b_ack, div_output_z, div_output_z_stb,
        input  req_ready, rsp_valid, rsp_z, busy,
        input  div_rst, div_input_a, div_input_a_stb, div_input_b, div_input_b_stb,
        input  div_output_z_ack
    );

endinterface : divider_arbiter_if
`default_nettype wire

// File: rtl/divider_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : divider_arbiter_rr_arbiter
// Purpose  : Combinational round-robin pick: first requesting index at or
//            above the pointer, wrapping past N_REQ-1 back to 0.
// Revision : 1.0 - initial release
// ============================================================================
module divider_arbiter_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  wire logic [N_REQ-1:0] i_req,
    input  wire logic [IDX_W-1:0] i_rr_ptr,
    output logic      [N_REQ-1:0] o_grant,
    output logic      [IDX_W-1:0] o_grant_idx
);

    logic w_found;
    int   w_j;

    // Scan N_REQ positions starting at the pointer; first hit wins
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_j         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_j = int'(i_rr_ptr) + k;
            if (w_j >= N_REQ) begin
                w_j = w_j - N_REQ;
            end
            if (!w_found && i_req[w_j]) begin
                w_found        = 1'b1;
                o_grant[w_j]   = 1'b1;
                o_grant_idx    = IDX_W'(w_j);
            end
        end
    end

endmodule : divider_arbiter_rr_arbiter
`default_nettype wire

// File: rtl/divider_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : divider_arbiter
// Purpose  : Shares one FP32 divider (a/b/z strobe-ack) between N_REQ
//            requesters, round-robin, returning z only to the issuer.
// Revision : 1.0 - initial release
// ============================================================================
module divider_arbiter
    import divider_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    divider_arbiter_if.slave bus
);

    logic [2:0]       r_state;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_owner;
    fp32_t            r_a;
    fp32_t            r_b;
    fp32_t            r_z;
    logic [1:0]       r_rst_sync;

    logic [N_REQ-1:0] w_grant;
    logic [IDX_W-1:0] w_grant_idx;
    logic             w_can_grant;

    divider_arbiter_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req       (bus.req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // Hold the divider in reset two edges past rst_n release so it restarts in get_a
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end

    assign w_can_grant = (r_state == c_IDLE) && !r_rst_sync[1] && (|bus.req_valid);

    // Operation sequencer: grant, feed a then b, collect z, deliver to owner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_z      <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_can_grant) begin
                        r_a     <= bus.req_a[c_FP32_W*w_grant_idx +: c_FP32_W];
                        r_b     <= bus.req_b[c_FP32_W*w_grant_idx +: c_FP32_W];
                        r_owner <= w_grant_idx;
                        r_state <= c_SEND_A;
                    end
                end
                c_SEND_A: begin
                    if (bus.div_input_a_ack) begin
                        r_state <= c_SEND_B;
                    end
                end
                c_SEND_B: begin
                    if (bus.div_input_b_ack) begin
                        r_state <= c_WAIT_Z;
                    end
                end
                c_WAIT_Z: begin
                    if (bus.div_output_z_stb) begin
                        r_z     <= bus.div_output_z;
                        r_state <= c_RESP;
                    end
                end
                c_RESP: begin
                    if (bus.rsp_ready[r_owner]) begin
                        r_state  <= c_IDLE;
                        r_rr_ptr <= (r_owner == IDX_W'(N_REQ-1)) ? '0 : r_owner + IDX_W'(1);
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs are decoded purely from state (grant also from requests)
    assign bus.req_ready        = w_can_grant ? w_grant : '0;
    assign bus.rsp_valid        = (r_state == c_RESP) ? (N_REQ'(1) << r_owner) : '0;
    assign bus.rsp_z            = r_z;
    assign bus.busy             = (r_state != c_IDLE);
    assign bus.div_rst          = r_rst_sync[1];
    assign bus.div_input_a      = r_a;
    assign bus.div_input_a_stb  = (r_state == c_SEND_A);
    assign bus.div_input_b      = r_b;
    assign bus.div_input_b_stb  = (r_state == c_SEND_B);
    assign bus.div_output_z_ack = (r_state == c_WAIT_Z);

endmodule : divider_arbiter
`default_nettype wire
